cpu_step_checker: RTL

CPU_STEP_CHECKER -- requirements
Module: cpu_step_checker

---
 rtl/risc_dbg_pkg.sv | 16 +
 rtl/cpu_step_checker_chk_table.sv | 30 +++
 rtl/cpu_step_checker.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/risc_dbg_pkg.sv
// Shared types for the CPU step checker.
// Holds the FSM state encoding and the session mode constants.
package risc_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_CHECK = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    localparam logic MODE_RUN  = 1'b0;
    localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/cpu_step_checker_chk_table.sv
// Check table: DEPTH entries of {reg address, expected value}.
// Ports: write port (wr_en/wr_idx/wr_reg/wr_val), async read by rd_idx.
module chk_table #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 16,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [REG_AW-1:0] wr_reg,
    input  logic [XLEN-1:0]   wr_val,
    input  logic [IW-1:0]     rd_idx,
    output logic [REG_AW-1:0] rd_reg,
    output logic [XLEN-1:0]   rd_val
);

    // No reset: contents must survive a session abort.
    logic [REG_AW+XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= {wr_reg, wr_val};
        end
    end

    assign {rd_reg, rd_val} = mem_q[rd_idx];

endmodule

// File: rtl/cpu_step_checker.sv
// Drives a CPU in RUN or STEP mode and checks register values after each step.
// Ports: session control in, check-table write in, CPU control/debug out, results out.
module cpu_step_checker
    import risc_dbg_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic [XLEN-1:0]   start_pc,
    input  logic              chk_wr_en,
    input  logic [IW-1:0]     chk_wr_idx,
    input  logic [REG_AW-1:0] chk_wr_reg,
    input  logic [XLEN-1:0]   chk_wr_val,
    input  logic [IW:0]       chk_num,
    output logic              cpu_en,
    output logic              pc_load,
    output logic [XLEN-1:0]   pc_load_val,
    output logic [REG_AW-1:0] dbg_reg_addr,
    input  logic [XLEN-1:0]   dbg_reg_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IW:0]       fail_count,
    output logic [IW-1:0]     first_fail_idx,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
    logic [IW:0]       chk_num_q, chk_num_d;
    logic [XLEN-1:0]   start_pc_q, start_pc_d;
    logic [IW-1:0]     k_q, k_d;
    logic [IW:0]       fail_count_q, fail_count_d;
    logic [IW-1:0]     ffi_q, ffi_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              pass_q, pass_d;

    logic [REG_AW-1:0] tbl_reg;
    logic [XLEN-1:0]   tbl_val;
    logic              mismatch;
    logic [CNT_W-1:0]  cyc_inc;
    logic [IW:0]       k_inc;

    chk_table #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_tbl (
        .clk    (clk),
        .wr_en  (chk_wr_en && !busy),
        .wr_idx (chk_wr_idx),
        .wr_reg (chk_wr_reg),
        .wr_val (chk_wr_val),
        .rd_idx (k_q),
        .rd_reg (tbl_reg),
        .rd_val (tbl_val)
    );

    assign mismatch = (dbg_reg_data != tbl_val);
    assign cyc_inc  = cycle_count_q + CNT_W'(1);
    assign k_inc    = {1'b0, k_q} + (IW+1)'(1);

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        run_cycles_d  = run_cycles_q;
        chk_num_d     = chk_num_q;
        start_pc_d    = start_pc_q;
        k_d           = k_q;
        fail_count_d  = fail_count_q;
        ffi_d         = ffi_q;
        cycle_count_d = cycle_count_q;
        pass_d        = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_LOAD;
                    mode_d        = mode;
                    run_cycles_d  = run_cycles;
                    chk_num_d     = chk_num;
                    start_pc_d    = start_pc;
                    k_d           = '0;
                    fail_count_d  = '0;
                    ffi_d         = '0;
                    cycle_count_d = '0;
                    pass_d        = 1'b0;
                end
            end
            ST_LOAD: begin
                if ((mode_q == MODE_RUN && run_cycles_q == '0) ||
                    (mode_q == MODE_STEP && chk_num_q == '0)) begin
                    state_d = ST_FIN;
                    pass_d  = (fail_count_q == '0);
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cycle_count_d = cyc_inc;
                if (mode_q == MODE_STEP) begin
                    state_d = ST_CHECK;
                end else if (cyc_inc == run_cycles_q) begin
                    state_d = ST_FIN;
                    pass_d  = (fail_count_q == '0);
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (fail_count_q == '0) begin
                        ffi_d = k_q;
                    end
                    if (fail_count_q != DEPTH_C) begin
                        fail_count_d = fail_count_q + (IW+1)'(1);
                    end
                end
                // pass is resolved here so it is valid during the done cycle
                if (k_inc == chk_num_q) begin
                    state_d = ST_FIN;
                    pass_d  = (fail_count_d == '0);
                end else begin
                    k_d     = k_q + IW'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_RUN;
            run_cycles_q  <= '0;
            chk_num_q     <= '0;
            start_pc_q    <= '0;
            k_q           <= '0;
            fail_count_q  <= '0;
            ffi_q         <= '0;
            cycle_count_q <= '0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            run_cycles_q  <= run_cycles_d;
            chk_num_q     <= chk_num_d;
            start_pc_q    <= start_pc_d;
            k_q           <= k_d;
            fail_count_q  <= fail_count_d;
            ffi_q         <= ffi_d;
            cycle_count_q <= cycle_count_d;
            pass_q        <= pass_d;
        end
    end

    assign cpu_en         = (state_q == ST_EXEC);
    assign pc_load        = (state_q == ST_LOAD);
    assign pc_load_val    = pc_load ? start_pc_q : '0;
    assign dbg_reg_addr   = (state_q == ST_CHECK) ? tbl_reg : '0;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FIN);
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = ffi_q;
    assign cycle_count    = cycle_count_q;

endmodule
